// File: rtl/mem_lsu.sv
// Load/store unit: turns byte/half/word core requests into 32b word accesses on a memory
// without byte enables, using read-modify-write for sub-word stores.
module mem_lsu #(
    parameter int unsigned ROWS = 512
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_r_en_o,
    output logic [31:0] mem_addr_r_o,
    input  logic [31:0] mem_data_r_i,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_addr_w_o,
    output logic [31:0] mem_data_w_o
);

    typedef enum logic [2:0] {StIdle, StRd, StRdw, StWr, StResp} state_e;

    state_e      r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [31:0] r_word;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_bad;
    logic [4:0]  w_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_accept = req_valid_i && (r_state == StIdle);

    // Misalignment, illegal size or word index past the end of memory
    always_comb begin
        w_bad = 1'b0;
        unique case (req_size_i)
            2'b00:   w_bad = 1'b0;
            2'b01:   w_bad = req_addr_i[0];
            2'b10:   w_bad = (req_addr_i[1:0] != 2'b00);
            default: w_bad = 1'b1;
        endcase
        if ({2'b00, req_addr_i[31:2]} >= 32'(ROWS)) begin
            w_bad = 1'b1;
        end
    end

    assign w_sh   = {r_addr[1:0], 3'b000};
    assign w_byte = mem_data_r_i[w_sh +: 8];
    assign w_half = r_addr[1] ? mem_data_r_i[31:16] : mem_data_r_i[15:0];

    always_comb begin
        w_load   = mem_data_r_i;
        w_merged = mem_data_r_i;
        unique case (r_size)
            2'b00: begin
                w_load = {{24{~r_uns & w_byte[7]}}, w_byte};
                w_merged[w_sh +: 8] = r_word[7:0];
            end
            2'b01: begin
                w_load = {{16{~r_uns & w_half[15]}}, w_half};
                if (r_addr[1]) begin
                    w_merged[31:16] = r_word[15:0];
                end else begin
                    w_merged[15:0] = r_word[15:0];
                end
            end
            default: begin
                w_load   = mem_data_r_i;
                w_merged = r_word;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_word  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_we   <= req_we_i;
                        r_size <= req_size_i;
                        r_uns  <= req_unsigned_i;
                        r_addr <= req_addr_i;
                        // Store data parks in the write-data register until merged
                        if (req_we_i) begin
                            r_word <= req_wdata_i;
                        end
                        if (w_bad) begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                            r_state <= StResp;
                        end else if (!req_we_i || (req_size_i != 2'b10)) begin
                            r_state <= StRd;
                        end else begin
                            r_state <= StWr;
                        end
                    end
                end
                StRd: r_state <= StRdw;
                StRdw: begin
                    if (r_we) begin
                        r_word  <= w_merged;
                        r_state <= StWr;
                    end else begin
                        r_rdata <= w_load;
                        r_err   <= 1'b0;
                        r_state <= StResp;
                    end
                end
                StWr: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    r_state <= StResp;
                end
                StResp:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign req_ready_o  = (r_state == StIdle);
    assign resp_valid_o = (r_state == StResp);
    assign mem_r_en_o   = (r_state == StRd);
    assign mem_wr_en_o  = (r_state == StWr);
    assign mem_addr_r_o = {r_addr[31:2], 2'b00};
    assign mem_addr_w_o = {r_addr[31:2], 2'b00};
    assign mem_data_w_o = r_word;
    assign resp_rdata_o = r_rdata;
    assign resp_err_o   = r_err;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a behavioural word memory (read data one cycle after enable).
`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) passes++; \
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, (obs), (exp)); \
    end

module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_uns = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_r_en;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_data_r = '0;
    logic        mem_wr_en;
    logic [31:0] mem_addr_w;
    logic [31:0] mem_data_w;

    logic [31:0] mem [512];
    logic        pl_en = 1'b0;
    logic [8:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          acc_cnt = 0;
    int          both_cnt = 0;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mem_lsu #(.ROWS(512)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_uns),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .resp_valid_o   (resp_valid),
        .resp_rdata_o   (resp_rdata),
        .resp_err_o     (resp_err),
        .mem_r_en_o     (mem_r_en),
        .mem_addr_r_o   (mem_addr_r),
        .mem_data_r_i   (mem_data_r),
        .mem_wr_en_o    (mem_wr_en),
        .mem_addr_w_o   (mem_addr_w),
        .mem_data_w_o   (mem_data_w)
    );

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        if (mem_wr_en) begin
            mem[mem_addr_w[10:2]] <= mem_data_w;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_r_en) begin
            mem_data_r <= mem[mem_addr_r[10:2]];
            rd_cnt <= rd_cnt + 1;
        end
        if (mem_r_en && mem_wr_en) both_cnt <= both_cnt + 1;
        if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic preload(input logic [8:0] idx, input logic [31:0] data);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_idx  = idx;
        pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issue one request; lat counts edges from accept to resp_valid (20 = timed out)
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er);
        int t;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!req_ready) begin
            $error("FAIL ready_wait: req_ready not seen within %0d cycles", t);
        end else begin
            passes++;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_uns   = uns;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (!resp_valid) begin
            $error("FAIL resp_wait: resp_valid not seen within %0d cycles", lat);
        end else begin
            passes++;
        end
        rd = resp_rdata;
        er = resp_err;
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          r0;
        int          w0;
        int          a0;
        int          nresp;
        int          nacc;
        int          nready;
        int          cyc;
        logic [31:0] got [3];
        logic [31:0] addrs [3];

        for (int i = 0; i < 512; i++) mem[i] = '0;

        #1;
        checks++;
        if (req_ready !== 1'b1) $error("FAIL reset_ready: observed %b", req_ready);
        else passes++;
        checks++;
        if (resp_valid !== 1'b0) $error("FAIL reset_resp_valid: observed %b", resp_valid);
        else passes++;
        checks++;
        if (resp_rdata !== 32'h0) $error("FAIL reset_rdata: observed 0x%0h", resp_rdata);
        else passes++;
        checks++;
        if (resp_err !== 1'b0) $error("FAIL reset_err: observed %b", resp_err);
        else passes++;
        checks++;
        if (mem_r_en !== 1'b0) $error("FAIL reset_r_en: observed %b", mem_r_en);
        else passes++;
        checks++;
        if (mem_wr_en !== 1'b0) $error("FAIL reset_wr_en: observed %b", mem_wr_en);
        else passes++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Word store then word load
        w0 = wr_cnt; r0 = rd_cnt;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er);
        `CHK("sw_lat", lat, 2)
        `CHK("sw_rdata", rd, 32'h0)
        `CHK("sw_err", er, 1'b0)
        #2;
        `CHK("sw_wr_once", wr_cnt - w0, 1)
        `CHK("sw_no_read", rd_cnt - r0, 0)
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
        `CHK("lw_lat", lat, 3)
        `CHK("lw_rdata", rd, 32'hDEADBEEF)
        @(posedge clk);
        #1;
        `CHK("rdata_hold", resp_rdata, 32'hDEADBEEF)

        // Sub-word stores via read-modify-write
        preload(9'd4, 32'h11223344);
        w0 = wr_cnt; r0 = rd_cnt;
        do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, lat, rd, er);
        `CHK("sb_lat", lat, 4)
        `CHK("sb_err", er, 1'b0)
        `CHK("sb_one_read", rd_cnt - r0, 1)
        `CHK("sb_one_write", wr_cnt - w0, 1)
        `CHK("sb_mem", mem[4], 32'h11AA3344)
        do_req(1'b1, 2'b01, 1'b0, 32'h10, 32'h00005566, lat, rd, er);
        `CHK("sh_lat", lat, 4)
        `CHK("sh_mem", mem[4], 32'h11AA5566)

        // Sign/zero extension of loads
        preload(9'd8, 32'h80F07F01);
        do_req(1'b0, 2'b00, 1'b0, 32'h22, 32'h0, lat, rd, er);
        `CHK("lb", rd, 32'hFFFFFFF0)
        do_req(1'b0, 2'b00, 1'b1, 32'h22, 32'h0, lat, rd, er);
        `CHK("lbu", rd, 32'h000000F0)
        do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, lat, rd, er);
        `CHK("lh", rd, 32'hFFFF80F0)
        do_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, lat, rd, er);
        `CHK("lhu", rd, 32'h00007F01)
        `CHK("lhu_lat", lat, 3)

        // Error responses: no memory traffic, one cycle
        w0 = wr_cnt; r0 = rd_cnt;
        do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, lat, rd, er);
        `CHK("lw_mis_lat", lat, 1)
        `CHK("lw_mis_err", er, 1'b1)
        `CHK("lw_mis_rdata", rd, 32'h0)
        do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, lat, rd, er);
        `CHK("lh_mis_err", er, 1'b1)
        `CHK("lh_mis_lat", lat, 1)
        do_req(1'b1, 2'b11, 1'b0, 32'h0, 32'h12345678, lat, rd, er);
        `CHK("size11_err", er, 1'b1)
        `CHK("size11_lat", lat, 1)
        do_req(1'b0, 2'b10, 1'b0, 32'h800, 32'h0, lat, rd, er);
        `CHK("oor_err", er, 1'b1)
        `CHK("oor_rdata", rd, 32'h0)
        `CHK("err_no_read", rd_cnt - r0, 0)
        `CHK("err_no_write", wr_cnt - w0, 0)

        // Reset during RDW of a byte store
        preload(9'd9, 32'h12345678);
        w0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_uns = 1'b0;
        req_addr = 32'h24; req_wdata = 32'hFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        `CHK("rst_ready", req_ready, 1'b1)
        `CHK("rst_no_resp", resp_valid, 1'b0)
        `CHK("rst_no_wr_en", mem_wr_en, 1'b0)
        repeat (2) @(posedge clk);
        #1;
        `CHK("rst_no_write", wr_cnt - w0, 0)
        `CHK("rst_mem", mem[9], 32'h12345678)
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back loads with req_valid held high
        repeat (2) @(negedge clk);
        addrs[0] = 32'h10; addrs[1] = 32'h20; addrs[2] = 32'h24;
        a0 = acc_cnt; r0 = rd_cnt;
        nresp = 0; nacc = 0; nready = 0; cyc = 0;
        req_we = 1'b0; req_size = 2'b10; req_uns = 1'b0;
        for (int c = 0; c < 60 && nresp < 3; c++) begin
            @(negedge clk);
            cyc++;
            if (resp_valid) begin
                got[nresp] = resp_rdata;
                nresp++;
            end
            if (req_ready) begin
                nready++;
                if (nacc < 3) begin
                    req_addr  = addrs[nacc];
                    req_valid = 1'b1;
                    nacc++;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        checks++;
        if (nresp < 3) begin
            $error("FAIL b2b_wait: only %0d responses within %0d cycles", nresp, cyc);
        end else begin
            passes++;
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        `CHK("b2b_resp_count", nresp, 3)
        `CHK("b2b_accepts", acc_cnt - a0, 3)
        `CHK("b2b_ready_cycles", nready, 3)
        `CHK("b2b_reads", rd_cnt - r0, 3)
        `CHK("b2b_data0", got[0], 32'h11AA5566)
        `CHK("b2b_data1", got[1], 32'h80F07F01)
        `CHK("b2b_data2", got[2], 32'h12345678)
        `CHK("no_rw_overlap", both_cnt, 0)

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
